// File: rtl/key_extract_stage_if.sv
// Handshake and data bus for key_extract_stage.
// Signals keep the names of the stage's port list. The master modport is the side that
// drives beats in and consumes results; the slave modport is the stage itself.
//   i_valid/o_ready                 : upstream beat handshake
//   i_head/i_headLen/i_meta         : header window, valid header bytes, metadata
//   i_keyOffset/i_headShift/...     : lookup result aligned with the beat
//   o_valid/i_ready                 : downstream beat handshake
//   o_key/o_keyValid/o_head/o_meta  : extracted keys and shifted header/metadata
//   o_err                           : out-of-bound key flag
//   o_pktCnt                        : count of accepted beats
interface key_extract_stage_if #(
  parameter int unsigned HEAD_WIDTH       = 1024,
  parameter int unsigned META_WIDTH       = 512,
  parameter int unsigned KEY_FIELD_NUM    = 8,
  parameter int unsigned KEY_WIDTH        = 16,
  parameter int unsigned KEY_OFFSET_WIDTH = 6,
  parameter int unsigned HEAD_SHIFT_WIDTH = 6,
  parameter int unsigned META_SHIFT_WIDTH = 6
) ();

  logic                                          i_valid;
  logic                                          o_ready;
  logic [HEAD_WIDTH-1:0]                         i_head;
  logic [7:0]                                    i_headLen;
  logic [META_WIDTH-1:0]                         i_meta;
  logic [KEY_FIELD_NUM*(KEY_OFFSET_WIDTH+1)-1:0] i_keyOffset;
  logic [HEAD_SHIFT_WIDTH-1:0]                   i_headShift;
  logic [META_SHIFT_WIDTH-1:0]                   i_metaShift;
  logic                                          o_valid;
  logic                                          i_ready;
  logic [KEY_FIELD_NUM*KEY_WIDTH-1:0]            o_key;
  logic [KEY_FIELD_NUM-1:0]                      o_keyValid;
  logic [HEAD_WIDTH-1:0]                         o_head;
  logic [META_WIDTH-1:0]                         o_meta;
  logic                                          o_err;
  logic [31:0]                                   o_pktCnt;

  modport master (
    output i_valid, i_head, i_headLen, i_meta, i_keyOffset, i_headShift, i_metaShift, i_ready,
    input  o_ready, o_valid, o_key, o_keyValid, o_head, o_meta, o_err, o_pktCnt
  );

  modport slave (
    input  i_valid, i_head, i_headLen, i_meta, i_keyOffset, i_headShift, i_metaShift, i_ready,
    output o_ready, o_valid, o_key, o_keyValid, o_head, o_meta, o_err, o_pktCnt
  );

endinterface

// File: rtl/key_extract_stage.sv
// Key extraction stage following the type lookup.
// Registers the lookup result with its header window and metadata (S1), then extracts up to
// KEY_FIELD_NUM halfword keys from the unshifted header, left-shifts header and metadata by
// halfwords and registers the results (S2). Both stages advance under valid/ready with full
// backpressure; o_ready is combinational from i_ready (no skid buffer).
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset, clears every register
//   bus     : key_extract_stage_if.slave, beat in / result out plus o_err and o_pktCnt
// Build option: define KEY_BOUND_CHECK_EN to blank keys lying past i_headLen and raise o_err.
module key_extract_stage #(
  parameter int unsigned HEAD_WIDTH       = 1024,
  parameter int unsigned META_WIDTH       = 512,
  parameter int unsigned KEY_FIELD_NUM    = 8,
  parameter int unsigned KEY_WIDTH        = 16,
  parameter int unsigned KEY_OFFSET_WIDTH = 6,
  parameter int unsigned HEAD_SHIFT_WIDTH = 6,
  parameter int unsigned META_SHIFT_WIDTH = 6
) (
  input logic            i_clk,
  input logic            i_rst_n,
  key_extract_stage_if.slave bus
);

  localparam int unsigned KOW   = KEY_OFFSET_WIDTH + 1;
  localparam int unsigned IDX_W = $clog2(HEAD_WIDTH);

  // S1 registers
  logic                             s1_valid_q;
  logic [HEAD_WIDTH-1:0]            s1_head_q;
  logic [META_WIDTH-1:0]            s1_meta_q;
  logic [KEY_FIELD_NUM*KOW-1:0]     s1_key_offset_q;
  logic [HEAD_SHIFT_WIDTH-1:0]      s1_head_shift_q;
  logic [META_SHIFT_WIDTH-1:0]      s1_meta_shift_q;

  // S2 registers
  logic                             s2_valid_q;
  logic [KEY_FIELD_NUM*KEY_WIDTH-1:0] key_q;
  logic [KEY_FIELD_NUM-1:0]         key_valid_q;
  logic [HEAD_WIDTH-1:0]            head_q;
  logic [META_WIDTH-1:0]            meta_q;
  logic [31:0]                      pkt_cnt_q;

  // S2 next-state values
  logic [KEY_FIELD_NUM*KEY_WIDTH-1:0] key_d;
  logic [KEY_FIELD_NUM-1:0]         key_valid_d;
  logic [KEY_FIELD_NUM-1:0]         oob_vec;
  logic [HEAD_WIDTH-1:0]            head_d;
  logic [META_WIDTH-1:0]            meta_d;

  logic s1_adv, s2_adv, accept;

  assign s2_adv      = ~s2_valid_q | bus.i_ready;
  assign s1_adv      = ~s1_valid_q | s2_adv;
  assign accept      = bus.i_valid & s1_adv;
  assign bus.o_ready = s1_adv;

`ifdef KEY_BOUND_CHECK_EN
  localparam int unsigned BW = KEY_OFFSET_WIDTH + 3;
  logic [7:0] s1_head_len_q;
  logic       err_q;
`else
  // Header length only matters to the bound check.
  logic unused_head_len;
  assign unused_head_len = ^bus.i_headLen;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q      <= 1'b0;
      s1_head_q       <= '0;
      s1_meta_q       <= '0;
      s1_key_offset_q <= '0;
      s1_head_shift_q <= '0;
      s1_meta_shift_q <= '0;
`ifdef KEY_BOUND_CHECK_EN
      s1_head_len_q   <= '0;
`endif
    end else if (s1_adv) begin
      s1_valid_q      <= bus.i_valid;
      s1_head_q       <= bus.i_head;
      s1_meta_q       <= bus.i_meta;
      s1_key_offset_q <= bus.i_keyOffset;
      s1_head_shift_q <= bus.i_headShift;
      s1_meta_shift_q <= bus.i_metaShift;
`ifdef KEY_BOUND_CHECK_EN
      s1_head_len_q   <= bus.i_headLen;
`endif
    end
  end

  for (genvar j = 0; j < KEY_FIELD_NUM; j++) begin : g_key
    logic [KEY_OFFSET_WIDTH-1:0] off;
    logic                        hit;
    logic                        oob;
    logic [IDX_W-1:0]            base;

    assign off  = s1_key_offset_q[j*KOW +: KEY_OFFSET_WIDTH];
    assign hit  = s1_key_offset_q[j*KOW + KEY_OFFSET_WIDTH];
    // Halfword 'off' counted from the MSB end of the header window.
    assign base = IDX_W'(HEAD_WIDTH - KEY_WIDTH) - IDX_W'(KEY_WIDTH * off);
`ifdef KEY_BOUND_CHECK_EN
    // Field occupies bytes 2*off and 2*off+1; both must lie within headLen.
    assign oob  = hit & ((BW'({off, 1'b0}) + BW'(2)) > BW'(s1_head_len_q));
`else
    assign oob  = 1'b0;
`endif
    assign oob_vec[j]     = oob;
    assign key_valid_d[j] = hit & ~oob;
    assign key_d[j*KEY_WIDTH +: KEY_WIDTH] =
        key_valid_d[j] ? s1_head_q[base +: KEY_WIDTH] : '0;
  end

  // Shifts are in 16-bit halfwords; oversized meta shifts naturally yield zero.
  assign head_d = s1_head_q << {s1_head_shift_q, 4'b0000};
  assign meta_d = s1_meta_q << {s1_meta_shift_q, 4'b0000};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q  <= 1'b0;
      key_q       <= '0;
      key_valid_q <= '0;
      head_q      <= '0;
      meta_q      <= '0;
`ifdef KEY_BOUND_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else if (s2_adv) begin
      s2_valid_q  <= s1_valid_q;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      head_q      <= head_d;
      meta_q      <= meta_d;
`ifdef KEY_BOUND_CHECK_EN
      err_q       <= |oob_vec;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q <= '0;
    end else if (accept) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign bus.o_valid    = s2_valid_q;
  assign bus.o_key      = key_q;
  assign bus.o_keyValid = key_valid_q;
  assign bus.o_head     = head_q;
  assign bus.o_meta     = meta_q;
  assign bus.o_pktCnt   = pkt_cnt_q;
`ifdef KEY_BOUND_CHECK_EN
  assign bus.o_err      = err_q;
`else
  logic unused_oob;
  assign unused_oob = ^oob_vec;
  assign bus.o_err  = 1'b0;
`endif

endmodule

// File: doc/key_extract_stage.md
Name: key_extract_stage

Overview:
- Stage directly downstream of the type-lookup stage in the parser/deparser pipeline.
- Consumes the lookup result (key offsets, head shift, meta shift) together with the header window and metadata it belongs to.
- Extracts the key fields, shifts the header and metadata, and passes everything on through a 2-stage valid/ready pipeline with full backpressure.

Parameters:
- HEAD_WIDTH, 1024, header window width in bits (128 B); byte 0 = bits [HEAD_WIDTH-1 -: 8]
- META_WIDTH, 512, metadata width in bits; byte 0 at MSB
- KEY_FIELD_NUM, 8, number of key fields
- KEY_WIDTH, 16, width of one key field (one halfword)
- KEY_OFFSET_WIDTH, 6, key offset width in halfwords (valid flag is one extra MSB)
- HEAD_SHIFT_WIDTH, 6, head shift width in halfwords
- META_SHIFT_WIDTH, 6, meta shift width in halfwords

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  stage can accept a beat
- i_head  in  HEAD_WIDTH  header window
- i_headLen  in  8  valid header bytes; used only with the optional feature
- i_meta  in  META_WIDTH  metadata
- i_keyOffset  in  KEY_FIELD_NUM*(KEY_OFFSET_WIDTH+1)  per field: bit[KEY_OFFSET_WIDTH] = valid, low bits = halfword offset
- i_headShift  in  HEAD_SHIFT_WIDTH  header left shift, in halfwords
- i_metaShift  in  META_SHIFT_WIDTH  metadata left shift, in halfwords
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready
- o_key  out  KEY_FIELD_NUM*KEY_WIDTH  extracted key fields
- o_keyValid  out  KEY_FIELD_NUM  per-field valid
- o_head  out  HEAD_WIDTH  shifted header
- o_meta  out  META_WIDTH  shifted metadata
- o_err  out  1  out-of-bound key flag (optional feature)
- o_pktCnt  out  32  count of accepted beats

Behaviour:
- Clocking and reset (decided): one clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset: every register clears, including data registers. o_valid=0, o_key=0, o_keyValid=0, o_head=0, o_meta=0, o_err=0, o_pktCnt=0.
- Input timing: inputs are sampled together, so the parent aligns the head/meta with the lookup result (lookup INSERT_ONE_CLK).
- Stage S1: registers i_head, i_headLen, i_meta, i_keyOffset, i_headShift, i_metaShift; holds s1_valid.
- Stage S2: computes keys and shifts from the S1 registers; holds the output registers and s2_valid (= o_valid).
- Handshake:
  - s2_adv = ~s2_valid | i_ready
  - s1_adv = ~s1_valid | s2_adv
  - o_ready = s1_adv, combinational from i_ready; no skid buffer
- Transfers:
  - Input accepted when i_valid & o_ready.
  - Output consumed when o_valid & i_ready.
- Stage updates:
  - On s1_adv: S1 loads the inputs and s1_valid <= i_valid.
  - On s2_adv: S2 loads the computed values and s2_valid <= s1_valid.
- Latency: 2 cycles from accept to o_valid when no stall; throughput 1 beat/cycle.
- Stall: while o_valid & ~i_ready, all outputs hold stable. Data registers load only on their stage's advance.
- Key extraction, per field j:
  - off = keyOffset[j][KEY_OFFSET_WIDTH-1:0]
  - If the valid bit is set: o_key[j] = head[HEAD_WIDTH-1-16*off -: 16] and o_keyValid[j]=1.
  - Else: o_key[j]=0 and o_keyValid[j]=0.
  - Extraction uses the unshifted header.
- Head shift: o_head = head << (16*headShift), zero fill; a shift of 64 halfwords is not reachable.
- Meta shift: o_meta = meta << (16*metaShift), zero fill. Shift >= META_WIDTH/16 gives all zeros.
- o_pktCnt: increments on each accepted input; wraps 0xFFFFFFFF -> 0.
- Reset mid-operation: both stages empty immediately; in-flight beats are dropped with no partial output.
- Simultaneous accept and drain with both stages full is legal; no bubble is inserted.

Optional Feature:
- Macro: KEY_BOUND_CHECK_EN.
- Defined:
  - A field with its valid bit set and 2*off+2 > headLen is out of bound.
  - For such a field: o_key[j]=0 and o_keyValid[j]=0.
  - o_err = OR over all fields of out-of-bound, registered with S2 and valid with o_valid.
  - headLen=0 makes every valid field out of bound.
- Undefined: no check; o_err tied 0; i_headLen unused.

Test Plan:
- Reset, then one beat:
  - stimulus: head bytes 0x00..0x7F, key0 = {1,6'd0}, key1 = {1,6'd5}, others invalid, headShift=7, ready=1
  - response: o_valid at cycle+2; key0=0x0001, key1=0x0A0B; keyValid=0x03; o_head byte0=0x0E, last 14 bytes 0; o_pktCnt=1
- Backpressure: stream 4 beats back-to-back, i_ready=0 for cycles 3-6 -> o_ready drops after 2 beats are buffered; outputs hold; all 4 beats emerge in order, no loss or duplication.
- Meta shift: meta byte i = i, metaShift=32 -> o_meta all zeros; metaShift=1 -> byte0=0x02, last 2 bytes 0.
- Counter wrap: force the counter to 0xFFFFFFFF, accept 1 beat -> o_pktCnt=0.
- Reset asserted while 2 beats are in flight -> o_valid=0 asynchronously; after release, no stale beat is output.
- KEY_BOUND_CHECK_EN: headLen=20, key0 off=9 valid (bytes 18-19) -> key0 valid, o_err=0; off=10 -> key0=0, keyValid[0]=0, o_err=1.
